// File: rtl/mem_port_arbiter.sv
// Arbitrates N bus masters onto the single main-memory port, holds a stalled grant,
// and routes each returning load to the port that owns its memory tag.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ARB_MODE  = 1,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [NUM_PORTS-1:0][1:0]         req_command,
    input  logic [NUM_PORTS-1:0][1:0]         req_size,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  req_data,
    output logic [NUM_PORTS-1:0]              req_accept,
    output logic [TAG_W-1:0]                  req_resp_tag,
    output logic [NUM_PORTS-1:0]              resp_valid,
    output logic [DATA_W-1:0]                 resp_data,
    output logic [TAG_W-1:0]                  resp_tag,
    output logic [1:0]                        mem_command,
    output logic [1:0]                        mem_size,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_data,
    input  logic [TAG_W-1:0]                  mem_response,
    input  logic [DATA_W-1:0]                 mem_rdata,
    input  logic [TAG_W-1:0]                  mem_tag,
    output logic                              err_orphan,
    output logic                              err_realloc
);

    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int NTAGS  = 1 << TAG_W;
    localparam logic [1:0] BUS_NONE = 2'h0;
    localparam logic [1:0] BUS_LOAD = 2'h1;

    logic [NTAGS-1:0]  tbl_valid_q;
    logic [PORT_W-1:0] tbl_owner_q [NTAGS];
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic              lock_valid_q, lock_valid_d;
    logic [PORT_W-1:0] lock_port_q, lock_port_d;
    logic              err_orphan_q, err_orphan_d;
    logic              err_realloc_q, err_realloc_d;

    logic              sel_valid;
    logic [PORT_W-1:0] sel;
    logic              accept;
    logic              alloc;
    logic              hit;
    logic              same_tag;

    // A held grant wins only while its owner keeps requesting; otherwise normal search.
    always_comb begin : select_port
        logic [PORT_W-1:0] cand;
        sel_valid = 1'b0;
        sel       = '0;
        cand      = '0;
        if (lock_valid_q && (req_command[lock_port_q] != BUS_NONE)) begin
            sel_valid = 1'b1;
            sel       = lock_port_q;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (ARB_MODE == 1) begin
                    cand = PORT_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
                end else begin
                    cand = PORT_W'(i);
                end
                if (!sel_valid && (req_command[cand] != BUS_NONE)) begin
                    sel_valid = 1'b1;
                    sel       = cand;
                end
            end
        end
    end

    assign accept   = reset_n && sel_valid && (mem_response != '0);
    assign alloc    = accept && (req_command[sel] == BUS_LOAD);
    assign hit      = reset_n && (mem_tag != '0) && tbl_valid_q[mem_tag];
    assign same_tag = hit && (mem_tag == mem_response);

    always_comb begin
        mem_command  = BUS_NONE;
        mem_size     = '0;
        mem_addr     = '0;
        mem_data     = '0;
        if (reset_n && sel_valid) begin
            mem_command = req_command[sel];
            mem_size    = req_size[sel];
            mem_addr    = req_addr[sel];
            mem_data    = req_data[sel];
        end
        req_accept   = '0;
        req_resp_tag = '0;
        if (accept) begin
            req_accept[sel] = 1'b1;
            req_resp_tag    = mem_response;
        end
        resp_valid = '0;
        if (hit) begin
            resp_valid[tbl_owner_q[mem_tag]] = 1'b1;
        end
        resp_data = reset_n ? mem_rdata : '0;
        resp_tag  = reset_n ? mem_tag   : '0;
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_valid_d = 1'b0;
        lock_port_d  = lock_port_q;
        if (sel_valid && !accept) begin
            lock_valid_d = 1'b1;
            lock_port_d  = sel;
        end
        if ((ARB_MODE == 1) && accept) begin
            rr_ptr_d = (sel == PORT_W'(NUM_PORTS - 1)) ? '0 : sel + PORT_W'(1);
        end
        err_orphan_d  = err_orphan_q | ((mem_tag != '0) && !tbl_valid_q[mem_tag]);
        // A tag completing and being reissued in the same cycle is a legal handover.
        err_realloc_d = err_realloc_q | (alloc && tbl_valid_q[mem_response] && !same_tag);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tbl_valid_q <= '0;
            for (int t = 0; t < NTAGS; t++) begin
                tbl_owner_q[t] <= '0;
            end
            rr_ptr_q      <= '0;
            lock_valid_q  <= 1'b0;
            lock_port_q   <= '0;
            err_orphan_q  <= 1'b0;
            err_realloc_q <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            lock_valid_q  <= lock_valid_d;
            lock_port_q   <= lock_port_d;
            err_orphan_q  <= err_orphan_d;
            err_realloc_q <= err_realloc_d;
            // Clear on completion first so a same-cycle reallocation overrides it.
            if (hit) begin
                tbl_valid_q[mem_tag] <= 1'b0;
            end
            if (alloc) begin
                tbl_valid_q[mem_response] <= 1'b1;
                tbl_owner_q[mem_response] <= sel;
            end
        end
    end

    assign err_orphan  = err_orphan_q;
    assign err_realloc = err_realloc_q;

endmodule
